// File: rtl/text_rx_deframer.sv
// Serial text deframer: sync hunt, length-prefixed payload recovery, payload FIFO with valid/ready drain.
// Optional checksum byte after the payload when TEXT_RX_CHKSUM_EN is defined.
module text_rx_deframer #(
  parameter logic [7:0] SYNC_WORD  = 8'h7E,
  parameter int         FIFO_DEPTH = 16,
  parameter int         FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

`ifdef TEXT_RX_CHKSUM_EN
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
`else
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             state_reg, state_next;
  logic [7:0]         shreg_reg, shreg_next;
  logic [2:0]         bit_cnt_reg, bit_cnt_next;
  logic [7:0]         byte_cnt_reg, byte_cnt_next;
  logic [7:0]         len_reg, len_next;
  logic               frame_done_reg, frame_done_next;
  logic               overflow_reg, overflow_next;
`ifdef TEXT_RX_CHKSUM_EN
  logic [7:0]         chk_reg, chk_next;
  logic               frame_err_reg, frame_err_next;
`endif
  logic [FIFO_AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FIFO_AW:0]   count_reg, count_next;
  logic [7:0]         data_out_reg;
  logic [7:0]         mem [FIFO_DEPTH];

  logic [7:0] shift_in;
  logic       byte_end;
  logic       frame_end;
  logic       push_req, push, pop, full;

  assign shift_in = {shreg_reg[6:0], bit_in};
  assign byte_end = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= HUNT;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      byte_cnt_reg   <= '0;
      len_reg        <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
`ifdef TEXT_RX_CHKSUM_EN
      chk_reg        <= '0;
      frame_err_reg  <= 1'b0;
`endif
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      len_reg        <= len_next;
      frame_done_reg <= frame_done_next;
      overflow_reg   <= overflow_next;
`ifdef TEXT_RX_CHKSUM_EN
      chk_reg        <= chk_next;
      frame_err_reg  <= frame_err_next;
`endif
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    len_next        = len_reg;
    frame_done_next = 1'b0;
    frame_end       = 1'b0;
    push_req        = 1'b0;
`ifdef TEXT_RX_CHKSUM_EN
    chk_next        = chk_reg;
    frame_err_next  = 1'b0;
`endif
    if (bit_valid) begin
      shreg_next   = shift_in;
      bit_cnt_next = bit_cnt_reg + 3'd1;
      case (state_reg)
        HUNT: begin
          if (shift_in == SYNC_WORD) begin
            state_next   = LEN;
            bit_cnt_next = '0;
`ifdef TEXT_RX_CHKSUM_EN
            chk_next     = '0;
`endif
          end
        end
        LEN: begin
          if (byte_end) begin
            len_next      = shift_in;
            byte_cnt_next = '0;
            state_next    = PAYLOAD;
`ifdef TEXT_RX_CHKSUM_EN
            chk_next      = shift_in;
            if (shift_in == 8'h00) state_next = CHK;
`else
            if (shift_in == 8'h00) frame_end = 1'b1;
`endif
          end
        end
        PAYLOAD: begin
          if (byte_end) begin
            // Dropped bytes still count toward the length and the checksum.
            push_req      = 1'b1;
            byte_cnt_next = byte_cnt_reg + 8'd1;
`ifdef TEXT_RX_CHKSUM_EN
            chk_next      = chk_reg ^ shift_in;
            if (byte_cnt_reg + 8'd1 == len_reg) state_next = CHK;
`else
            if (byte_cnt_reg + 8'd1 == len_reg) frame_end = 1'b1;
`endif
          end
        end
`ifdef TEXT_RX_CHKSUM_EN
        CHK: begin
          if (byte_end) begin
            frame_end      = 1'b1;
            frame_err_next = (shift_in != chk_reg);
          end
        end
`endif
        default: state_next = HUNT;
      endcase
      // Clearing the shift register keeps the tail of this frame from forming a false sync.
      if (frame_end) begin
        state_next      = HUNT;
        shreg_next      = '0;
        frame_done_next = 1'b1;
      end
    end
  end

  always_comb begin
    full          = (count_reg == FULL_COUNT);
    pop           = (count_reg != '0) && data_ready;
    push          = push_req && (!full || pop);
    overflow_next = overflow_reg || (push_req && full && !pop);
    wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next    = count_reg + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_in;
  end

  // Head register: bypass when the slot being written becomes the new head.
  always_ff @(posedge clk) begin
    if (reset)
      data_out_reg <= '0;
    else if (push && (wr_ptr_reg == rd_ptr_next))
      data_out_reg <= shift_in;
    else if (count_next != '0)
      data_out_reg <= mem[rd_ptr_next];
  end

  assign data_out   = data_out_reg;
  assign data_valid = (count_reg != '0);
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;
  assign busy       = (state_reg != HUNT);
`ifdef TEXT_RX_CHKSUM_EN
  assign frame_err  = frame_err_reg;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_text_rx_deframer.sv
// Scoreboard bench for text_rx_deframer: stimulus queues expected bytes/frame results, a negedge monitor checks them.
module tb_text_rx_deframer;
  logic       clk = 1'b0;
  logic       reset, bit_in, bit_valid, data_ready;
  logic [7:0] data_out;
  logic       data_valid, frame_done, frame_err, overflow, busy;

  int         checks = 0;
  int         failures = 0;
  int         gap = 4;
  logic [7:0] exp_q[$];
  logic       exp_err_q[$];
  logic [7:0] pay [0:31];
  logic [7:0] exp_b;
  logic       exp_e;
  logic       prev_done = 1'b0;
  logic [7:0] a5 = 8'hA5;

  text_rx_deframer #(.SYNC_WORD(8'h7E), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a byte or ends a frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte actual=0x%0h required=none", data_out);
        end else begin
          exp_b = exp_q.pop_front();
          check("data_out", data_out, exp_b);
        end
      end
      if (frame_done) begin
        check("frame_done_width", prev_done, 1'b0);
        if (exp_err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_done actual=1 required=0");
        end else begin
          exp_e = exp_err_q.pop_front();
          check("frame_err", frame_err, exp_e);
        end
      end else if (frame_err) begin
        checks++; failures++;
        $display("FAIL frame_err_without_done actual=1 required=0");
      end
      prev_done <= frame_done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    for (int i = 7; i >= 0; i--) begin
      bit_in = b[i]; bit_valid = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      if (last && i == 0) begin
        check("frame_done_timing", frame_done, 1'b1);
        check("busy_after_frame", busy, 1'b0);
      end
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
  endtask

  // Sends SYNC, LEN, pay[0..len-1] (and CHK when enabled); n_exp bytes are expected out of the FIFO.
  task automatic send_frame(input int len, input int n_exp, input bit bad_chk);
    logic [7:0] c;
    c = len[7:0];
    for (int i = 0; i < n_exp; i++) exp_q.push_back(pay[i]);
`ifdef TEXT_RX_CHKSUM_EN
    exp_err_q.push_back(bad_chk);
`else
    exp_err_q.push_back(1'b0);
`endif
    send_byte(8'h7E, 1'b0);
    check("busy_in_frame", busy, 1'b1);
`ifdef TEXT_RX_CHKSUM_EN
    send_byte(len[7:0], 1'b0);
    for (int i = 0; i < len; i++) begin
      c = c ^ pay[i];
      send_byte(pay[i], 1'b0);
    end
    send_byte(bad_chk ? (c ^ 8'h07) : c, 1'b1);
`else
    send_byte(len[7:0], len == 0);
    for (int i = 0; i < len; i++) send_byte(pay[i], i == len - 1);
`endif
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check(name, exp_q.size() + exp_err_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; data_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Empty frame, back-to-back bits
    gap = 1; data_ready = 1'b1;
    send_frame(0, 0, 1'b0);
    @(posedge clk); #1;
    check("len0_no_write", data_valid, 1'b0);
    wait_empty("len0_drain");

    // 7E 02 48 69 (23), bit every 4th cycle, then same frame with bad CHK 0x24
    gap = 4;
    pay[0] = 8'h48; pay[1] = 8'h69;
    send_frame(2, 2, 1'b0);
    wait_empty("hi_drain");
    send_frame(2, 2, 1'b1);
    wait_empty("hi_badchk_drain");

    // Garbage 1,0,1 then 0x3C (no shifted 0x7E image) before a 1-byte frame
    gap = 1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'h3C, 1'b0);
    check("hunt_idle", busy, 1'b0);
    pay[0] = 8'h41;
    send_frame(1, 1, 1'b0);
    wait_empty("hunt_drain");

    // Fill FIFO exactly, then push A5 in the same cycle as a pop
    data_ready = 1'b0;
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    send_frame(16, 16, 1'b0);
    check("full_valid", data_valid, 1'b1);
    check("full_no_overflow", overflow, 1'b0);
    exp_q.push_back(8'hA5);
    exp_err_q.push_back(1'b0);
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(a5[i]);
    bit_in = a5[0]; bit_valid = 1'b1; data_ready = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; data_ready = 1'b0;
`ifdef TEXT_RX_CHKSUM_EN
    send_byte(8'hA4, 1'b1);
`else
    check("frame_done_timing", frame_done, 1'b1);
`endif
    check("push_pop_no_overflow", overflow, 1'b0);
    data_ready = 1'b1;
    wait_empty("push_pop_drain");
    @(posedge clk); #1;
    check("push_pop_empty", data_valid, 1'b0);

    // Overflow: len=20 with no drain, only 0x00..0x0F kept
    data_ready = 1'b0;
    for (int i = 0; i < 20; i++) pay[i] = 8'(i);
    send_frame(20, 16, 1'b0);
    check("ovf_set", overflow, 1'b1);
    data_ready = 1'b1;
    wait_empty("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);

    // Reset after 9 payload bits with a byte waiting in the FIFO
    data_ready = 1'b0;
    send_byte(8'h7E, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_data_valid", data_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    data_ready = 1'b1;
    pay[0] = 8'h55;
    send_frame(1, 1, 1'b0);
    wait_empty("post_rst_drain");

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
